// File: rtl/accu_arbiter.sv
// Round-robin arbiter sharing one group accumulator between NUM_REQ sample streams.
// A granted requester supplies GROUP_LEN beats; the sum is then offered on a valid/ready port.
module accu_arbiter #(
   parameter  int NUM_REQ   = 4,
   parameter  int DATA_W    = 8,
   parameter  int GROUP_LEN = 4,
   localparam int CNT_W     = $clog2(GROUP_LEN),
   localparam int SUM_W     = DATA_W + CNT_W,
   localparam int ID_W      = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      sum_valid,
   input  logic                      sum_ready,
   output logic [SUM_W-1:0]          sum_data,
   output logic [ID_W-1:0]           sum_id,
   output logic                      busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t            state, state_d;
   logic [ID_W-1:0]   grant;
   logic [ID_W-1:0]   rr_ptr;
   logic [CNT_W-1:0]  beat_cnt;
   logic [SUM_W-1:0]  acc;
   logic [SUM_W-1:0]  sum_data_q;
   logic [ID_W-1:0]   sum_id_q;

   logic              arb_found;
   logic [ID_W-1:0]   arb_winner;
   logic [ID_W-1:0]   rr_next;
   logic [ID_W:0]     scan;
   logic [DATA_W-1:0] sample;
   logic [SUM_W-1:0]  sample_ext;
   logic              grant_valid;
   logic              take_grant;
   logic              accept;
   logic              last_beat;

   // Scan from rr_ptr upward, wrapping at NUM_REQ; first valid requester wins.
   always_comb begin
      arb_found  = 1'b0;
      arb_winner = '0;
      scan       = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         scan = {1'b0, rr_ptr} + (ID_W+1)'(i);
         if (scan >= (ID_W+1)'(NUM_REQ))
            scan = scan - (ID_W+1)'(NUM_REQ);
         if (!arb_found && req_valid[scan[ID_W-1:0]]) begin
            arb_found  = 1'b1;
            arb_winner = scan[ID_W-1:0];
         end
      end
   end

   assign rr_next = (arb_winner == ID_W'(NUM_REQ-1)) ? '0 : arb_winner + 1'b1;

   always_comb begin
      sample      = '0;
      grant_valid = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant == ID_W'(i)) begin
            sample      = req_data[i*DATA_W +: DATA_W];
            grant_valid = req_valid[i];
         end
      end
   end

   assign sample_ext = {{CNT_W{1'b0}}, sample};

   // Handshakes: a beat moves when req_valid[i] & req_ready[i] at a rising edge, a result
   // moves when sum_valid & sum_ready; ready/valid outputs depend on registered state only.
   always_comb begin
      state_d    = state;
      take_grant = 1'b0;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (arb_found) begin
               state_d    = COLLECT;
               take_grant = 1'b1;
            end
         end
         COLLECT: begin
            if (grant_valid) begin
               accept = 1'b1;
               if (beat_cnt == CNT_W'(GROUP_LEN-1))
                  state_d = DONE;
            end
         end
         DONE: begin
            if (sum_ready) begin
               if (arb_found) begin
                  state_d    = COLLECT;
                  take_grant = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign last_beat = accept && (beat_cnt == CNT_W'(GROUP_LEN-1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         grant      <= '0;
         rr_ptr     <= '0;
         beat_cnt   <= '0;
         acc        <= '0;
         sum_data_q <= '0;
         sum_id_q   <= '0;
      end else begin
         state <= state_d;
         if (take_grant) begin
            grant    <= arb_winner;
            rr_ptr   <= rr_next;
            beat_cnt <= '0;
            acc      <= '0;
         end else if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
            acc      <= (beat_cnt == '0) ? sample_ext : acc + sample_ext;
            if (last_beat) begin
               sum_data_q <= acc + sample_ext;
               sum_id_q   <= grant;
            end
         end
      end
   end

   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++)
         req_ready[i] = (state == COLLECT) && (grant == ID_W'(i));
   end

   assign sum_valid = (state == DONE);
   assign sum_data  = sum_data_q;
   assign sum_id    = sum_id_q;
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_accu_arbiter.sv
// Directed bench for accu_arbiter: vector table for single-requester groups and reset,
// plus hand sequences for round-robin rotation, stalls and result back-pressure.
module tb_accu_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        sum_valid;
   logic        sum_ready;
   logic [9:0]  sum_data;
   logic [1:0]  sum_id;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   accu_arbiter #(.NUM_REQ(4), .DATA_W(8), .GROUP_LEN(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .sum_valid (sum_valid),
      .sum_ready (sum_ready),
      .sum_data  (sum_data),
      .sum_id    (sum_id),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [3:0]  vld;
      logic [31:0] dat;
      logic        srdy;
      logic [3:0]  e_rdy;
      logic        e_sv;
      logic        chk_sum;
      logic [9:0]  e_sd;
      logic [1:0]  e_sid;
      logic        e_busy;
   } vec_t;

   vec_t vecs[23];
   int   rr_id[5] = '{0, 1, 2, 3, 0};
   int   rr_sd[5] = '{4, 8, 12, 16, 4};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drive inputs away from the edge, then sample outputs just after the next rising edge.
   task automatic step(input logic r, input logic [3:0] v, input logic [31:0] d, input logic s);
      rst       = r;
      req_valid = v;
      req_data  = d;
      sum_ready = s;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int k;
      int last_c;
      rst = 1'b1; req_valid = '0; req_data = '0; sum_ready = 1'b0;

      vecs[0]  = '{1'b1, 4'h0, 32'd0,         1'b1, 4'h0, 1'b0, 1'b1, 10'd0,    2'd0, 1'b0};
      vecs[1]  = '{1'b0, 4'h1, 32'd10,        1'b1, 4'h1, 1'b0, 1'b0, 10'd0,    2'd0, 1'b1};
      vecs[2]  = '{1'b0, 4'h1, 32'd10,        1'b1, 4'h1, 1'b0, 1'b0, 10'd0,    2'd0, 1'b1};
      vecs[3]  = '{1'b0, 4'h1, 32'd20,        1'b1, 4'h1, 1'b0, 1'b0, 10'd0,    2'd0, 1'b1};
      vecs[4]  = '{1'b0, 4'h1, 32'd30,        1'b1, 4'h1, 1'b0, 1'b0, 10'd0,    2'd0, 1'b1};
      vecs[5]  = '{1'b0, 4'h1, 32'd40,        1'b1, 4'h0, 1'b1, 1'b1, 10'd100,  2'd0, 1'b1};
      vecs[6]  = '{1'b0, 4'h0, 32'd0,         1'b1, 4'h0, 1'b0, 1'b0, 10'd0,    2'd0, 1'b0};
      vecs[7]  = '{1'b0, 4'h4, 32'h00FF0000,  1'b1, 4'h4, 1'b0, 1'b0, 10'd0,    2'd0, 1'b1};
      vecs[8]  = '{1'b0, 4'h4, 32'h00FF0000,  1'b1, 4'h4, 1'b0, 1'b0, 10'd0,    2'd0, 1'b1};
      vecs[9]  = '{1'b0, 4'h4, 32'h00FF0000,  1'b1, 4'h4, 1'b0, 1'b0, 10'd0,    2'd0, 1'b1};
      vecs[10] = '{1'b0, 4'h4, 32'h00FF0000,  1'b1, 4'h4, 1'b0, 1'b0, 10'd0,    2'd0, 1'b1};
      vecs[11] = '{1'b0, 4'h4, 32'h00FF0000,  1'b1, 4'h0, 1'b1, 1'b1, 10'd1020, 2'd2, 1'b1};
      vecs[12] = '{1'b0, 4'h0, 32'd0,         1'b1, 4'h0, 1'b0, 1'b0, 10'd0,    2'd0, 1'b0};
      vecs[13] = '{1'b0, 4'h1, 32'd5,         1'b1, 4'h1, 1'b0, 1'b0, 10'd0,    2'd0, 1'b1};
      vecs[14] = '{1'b0, 4'h1, 32'd5,         1'b1, 4'h1, 1'b0, 1'b0, 10'd0,    2'd0, 1'b1};
      vecs[15] = '{1'b0, 4'h1, 32'd5,         1'b1, 4'h1, 1'b0, 1'b0, 10'd0,    2'd0, 1'b1};
      vecs[16] = '{1'b1, 4'h1, 32'd5,         1'b1, 4'h0, 1'b0, 1'b1, 10'd0,    2'd0, 1'b0};
      vecs[17] = '{1'b0, 4'h1, 32'd1,         1'b1, 4'h1, 1'b0, 1'b0, 10'd0,    2'd0, 1'b1};
      vecs[18] = '{1'b0, 4'h1, 32'd1,         1'b1, 4'h1, 1'b0, 1'b0, 10'd0,    2'd0, 1'b1};
      vecs[19] = '{1'b0, 4'h1, 32'd1,         1'b1, 4'h1, 1'b0, 1'b0, 10'd0,    2'd0, 1'b1};
      vecs[20] = '{1'b0, 4'h1, 32'd1,         1'b1, 4'h1, 1'b0, 1'b0, 10'd0,    2'd0, 1'b1};
      vecs[21] = '{1'b0, 4'h1, 32'd1,         1'b1, 4'h0, 1'b1, 1'b1, 10'd4,    2'd0, 1'b1};
      vecs[22] = '{1'b0, 4'h0, 32'd0,         1'b1, 4'h0, 1'b0, 1'b0, 10'd0,    2'd0, 1'b0};

      @(negedge clk);
      for (int n = 0; n < 23; n++) begin
         step(vecs[n].rst, vecs[n].vld, vecs[n].dat, vecs[n].srdy);
         check($sformatf("v%0d req_ready", n), req_ready, vecs[n].e_rdy);
         check($sformatf("v%0d sum_valid", n), sum_valid, vecs[n].e_sv);
         check($sformatf("v%0d busy", n), busy, vecs[n].e_busy);
         if (vecs[n].chk_sum) begin
            check($sformatf("v%0d sum_data", n), sum_data, vecs[n].e_sd);
            check($sformatf("v%0d sum_id", n), sum_id, vecs[n].e_sid);
         end
      end

      // All four requesters continuously valid, lane i carries i+1.
      step(1'b1, 4'h0, 32'd0, 1'b1);
      step(1'b0, 4'hF, 32'h04030201, 1'b1);
      check("rr_first_grant", req_ready, 4'h1);
      k = 0;
      last_c = 0;
      for (int c = 1; c <= 40 && k < 5; c++) begin
         @(posedge clk);
         #1;
         check("rr_onehot_ready", ($countones(req_ready) <= 1), 1'b1);
         if (sum_valid) begin
            check($sformatf("rr_id%0d", k), sum_id, rr_id[k]);
            check($sformatf("rr_sum%0d", k), sum_data, rr_sd[k]);
            if (k > 0)
               check($sformatf("rr_spacing%0d", k), c - last_c, 5);
            last_c = c;
            k++;
         end
      end
      check("rr_result_count", k, 5);
      step(1'b0, 4'h0, 32'd0, 1'b1);
      check("rr_idle_busy", busy, 1'b0);

      // Requester 1 stalls mid-group while 3 waits; result then held under back-pressure.
      step(1'b1, 4'h0, 32'd0, 1'b0);
      step(1'b0, 4'b1010, {8'd9, 8'd0, 8'd3, 8'd0}, 1'b0);
      check("stall_grant", req_ready, 4'b0010);
      step(1'b0, 4'b1010, {8'd9, 8'd0, 8'd3, 8'd0}, 1'b0);
      check("stall_beat0", req_ready, 4'b0010);
      step(1'b0, 4'b1010, {8'd9, 8'd0, 8'd5, 8'd0}, 1'b0);
      check("stall_beat1", req_ready, 4'b0010);
      for (int g = 0; g < 3; g++) begin
         step(1'b0, 4'b1000, {8'd9, 8'd0, 8'd0, 8'd0}, 1'b0);
         check($sformatf("stall_gap%0d_ready", g), req_ready, 4'b0010);
         check($sformatf("stall_gap%0d_sv", g), sum_valid, 1'b0);
      end
      step(1'b0, 4'b1010, {8'd9, 8'd0, 8'd7, 8'd0}, 1'b0);
      check("stall_beat2", req_ready, 4'b0010);
      step(1'b0, 4'b1010, {8'd9, 8'd0, 8'd11, 8'd0}, 1'b0);
      check("stall_sv", sum_valid, 1'b1);
      check("stall_sum", sum_data, 10'd26);
      check("stall_id", sum_id, 2'd1);
      check("stall_done_ready", req_ready, 4'h0);
      for (int h = 0; h < 5; h++) begin
         step(1'b0, 4'b1010, {8'd9, 8'd0, 8'd0, 8'd0}, 1'b0);
         check($sformatf("hold%0d_sv", h), sum_valid, 1'b1);
         check($sformatf("hold%0d_sum", h), sum_data, 10'd26);
         check($sformatf("hold%0d_id", h), sum_id, 2'd1);
         check($sformatf("hold%0d_ready", h), req_ready, 4'h0);
      end
      step(1'b0, 4'b1000, {8'd9, 8'd0, 8'd0, 8'd0}, 1'b1);
      check("next_grant3", req_ready, 4'b1000);
      check("next_sv_low", sum_valid, 1'b0);
      for (int b = 0; b < 3; b++) begin
         step(1'b0, 4'b1000, {8'd9, 8'd0, 8'd0, 8'd0}, 1'b1);
         check($sformatf("r3_beat%0d", b), req_ready, 4'b1000);
      end
      step(1'b0, 4'b1000, {8'd9, 8'd0, 8'd0, 8'd0}, 1'b1);
      check("r3_sv", sum_valid, 1'b1);
      check("r3_sum", sum_data, 10'd36);
      check("r3_id", sum_id, 2'd3);
      step(1'b0, 4'h0, 32'd0, 1'b1);
      check("r3_idle", busy, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
